// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: sequencer state type and default operand-stream parameters shared with the downstream stage
package loop_seq_pkg;
  localparam int WIDTH_DEF = 3;
  localparam int LAST_DEF = 7;
  localparam int STEP_DEF = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/loop_index_counter.sv
// loop_index_counter: beat index counter with clear, enable and terminal-count flag
module loop_index_counter #(
  parameter int LAST = 7,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] cnt,
  output logic          tc
);
  logic [IW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + IW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc = cnt_q == IW'(LAST);
endmodule

// File: rtl/loop_operand_sequencer.sv
// loop_operand_sequencer: steps an index 0..LAST and streams seed+k*STEP operands over valid/ready
module loop_operand_sequencer
  import loop_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAST = LAST_DEF,
  parameter int STEP = STEP_DEF,
  parameter int IW = (LAST > 0) ? $clog2(LAST + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [WIDTH-1:0] seed_c,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             valid,
  input  logic             ready,
  output logic [IW-1:0]    index,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  state_e state_q, state_d;
  logic valid_q, valid_d, clr, en, tc;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  wire xfer = valid_q && ready;
  loop_index_counter #(.LAST(LAST), .IW(IW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .cnt(index), .tc(tc)
  );
  // abort overrides everything, including a same-cycle transfer or start
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    clr = 1'b0;
    en = 1'b0;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          valid_d = 1'b1;
          a_d = seed_a;
          b_d = seed_b;
          c_d = seed_c;
          clr = 1'b1;
        end
        RUN: if (xfer) begin
          if (tc) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            en = 1'b1;
            a_d = a_q + STEP_W;
            b_d = b_q + STEP_W;
            c_d = c_q + STEP_W;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign valid = valid_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_loop_operand_sequencer.sv
// tb_loop_operand_sequencer: scoreboard bench driving a STEP=1 and a STEP=3 sequencer with shared stimulus
module tb_loop_operand_sequencer;
  import loop_seq_pkg::*;
  localparam int W = 3;
  localparam int L = 7;
  typedef struct packed {logic [2:0] i, a, b, c;} beat_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, ready = 0;
  logic [W-1:0] sa = 0, sb = 0, sc = 0;
  logic [W-1:0] ao[2], bo[2], co[2];
  logic [2:0] io[2];
  logic vo[2], bs[2], dn[2];
  beat_t q[2][$];
  beat_t hold[2];
  bit done_due[2], abort_prev[2];
  int n_chk = 0, n_fail = 0, cyc = 0, stalls = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loop_operand_sequencer #(.WIDTH(W), .LAST(L), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed_a(sa), .seed_b(sb), .seed_c(sc), .a(ao[0]), .b(bo[0]), .c(co[0]),
    .valid(vo[0]), .ready(ready), .index(io[0]), .busy(bs[0]), .done(dn[0]));
  loop_operand_sequencer #(.WIDTH(W), .LAST(L), .STEP(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed_a(sa), .seed_b(sb), .seed_c(sc), .a(ao[1]), .b(bo[1]), .c(co[1]),
    .valid(vo[1]), .ready(ready), .index(io[1]), .busy(bs[1]), .done(dn[1]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // operand k of a run is seed + k*STEP modulo 2^W
  task automatic push_run(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
    beat_t e;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k <= L; k++) begin
        int s;
        s = d ? 3 : 1;
        e.i = 3'(k);
        e.a = 3'((int'(x) + k * s) % (1 << W));
        e.b = 3'((int'(y) + k * s) % (1 << W));
        e.c = 3'((int'(z) + k * s) % (1 << W));
        q[d].push_back(e);
      end
    end
  endtask

  task automatic rst_chk();
    for (int d = 0; d < 2; d++)
      chk("reset_outputs", 16'({io[d], ao[d], bo[d], co[d], vo[d], bs[d], dn[d]}), 16'(0));
  endtask

  // monitor: compares the presented beat with the scoreboard head every cycle it is valid
  always @(negedge clk) if (rst_n) begin
    for (int d = 0; d < 2; d++) begin
      chk("done_pulse", 16'(dn[d]), 16'(done_due[d]));
      done_due[d] = 0;
      chk("busy", 16'(bs[d]), 16'(vo[d] | dn[d]));
      if (abort_prev[d]) begin
        chk("abort_idle", 16'({vo[d], bs[d]}), 16'(0));
        chk("abort_hold", 16'({io[d], ao[d], bo[d], co[d]}), 16'(hold[d]));
        abort_prev[d] = 0;
      end
      if (vo[d]) begin
        if (q[d].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat dut%0d: got idx %0d a %0d, expected no beat", d, io[d], ao[d]);
        end else begin
          chk("beat", 16'({io[d], ao[d], bo[d], co[d]}), 16'(q[d][0]));
          if (ready) begin
            hold[d] = q[d].pop_front();
            if (int'(hold[d].i) == L && !abort) done_due[d] = 1;
          end else begin
            hold[d] = q[d][0];
            if (d == 0) stalls++;
          end
        end
      end
      if (abort && vo[d]) begin
        abort_prev[d] = 1;
        q[d].delete();
      end
    end
  end

  task automatic go(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                    output int t0, output int s0);
    @(posedge clk); #1;
    sa = x; sb = y; sc = z; start = 1;
    t0 = cyc;
    s0 = stalls;
    push_run(x, y, z);
    @(posedge clk); #1;
    start = 0;
    sa = 3'($urandom); sb = 3'($urandom); sc = 3'($urandom);
  endtask

  task automatic run(input int t0, input int s0, input int pct, input int stall_idx,
                     input int pulse_idx, input int abort_idx, input bit done_start);
    int budget, nst;
    bit fin, ab;
    budget = 400; nst = 0; fin = 0; ab = 0;
    while (!fin && budget > 0) begin
      ready = $urandom_range(99) < pct;
      start = vo[0] && int'(io[0]) == pulse_idx;
      if (start) begin sa = 3'($urandom); sb = 3'($urandom); sc = 3'($urandom); end
      if (vo[0] && int'(io[0]) == stall_idx && nst < 3) begin ready = 0; nst++; end
      if (vo[0] && int'(io[0]) == abort_idx) begin abort = 1; ready = 1; end
      @(posedge clk); #1;
      start = 0;
      if (abort) begin abort = 0; ab = 1; fin = 1; end
      else if (dn[0]) fin = 1;
      budget--;
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: got no done within 400 cycles, expected done");
    end else if (!ab) begin
      chk("latency", 16'(cyc - t0), 16'(L + 2 + stalls - s0));
      if (done_start) begin
        start = 1; sa = 3'($urandom); sb = 3'($urandom); sc = 3'($urandom);
        @(posedge clk); #1;
        start = 0;
      end
    end
  endtask

  initial begin
    int t0, s0, n, ai, si;
    #2 rst_chk();
    #20 rst_n = 1;
    @(posedge clk); #1 rst_chk();
    go(1, 2, 3, t0, s0);
    run(t0, s0, 100, -1, -1, -1, 0);
    go(3'($urandom), 3'($urandom), 3'($urandom), t0, s0);
    run(t0, s0, 100, 4, -1, -1, 0);
    chk("stall_cycles", 16'(stalls - s0), 16'(3));
    go(6, 3'($urandom), 3'($urandom), t0, s0);
    run(t0, s0, 100, -1, -1, -1, 0);
    go(3'($urandom), 3'($urandom), 3'($urandom), t0, s0);
    run(t0, s0, 100, -1, -1, 5, 0);
    go(3'($urandom), 3'($urandom), 3'($urandom), t0, s0);
    run(t0, s0, 100, -1, 2, -1, 1);
    go(3'($urandom), 3'($urandom), 3'($urandom), t0, s0);
    n = 0;
    while (!(vo[0] && io[0] == 3'd3) && n < 50) begin
      ready = 1;
      @(posedge clk); #1;
      n++;
    end
    ready = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1 rst_chk();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      done_due[d] = 0;
      abort_prev[d] = 0;
    end
    #2 rst_n = 1;
    go(3'($urandom), 3'($urandom), 3'($urandom), t0, s0);
    run(t0, s0, 100, -1, -1, -1, 0);
    repeat (20) begin
      ai = ($urandom_range(3) == 0) ? int'($urandom_range(L)) : -1;
      si = ($urandom_range(1) == 0) ? int'($urandom_range(L)) : -1;
      go(3'($urandom), 3'($urandom), 3'($urandom), t0, s0);
      run(t0, s0, 40 + int'($urandom_range(60)), si, int'($urandom_range(L)), ai, 1'($urandom_range(1)));
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("queue_drained", 16'(q[d].size()), 16'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
